irq_claim_agent: RTL
====================

IRQ_CLAIM_AGENT -- requirements
Module: irq_claim_agent

Interface
REQ-001 SHALL have parameter CC_ADDR, default 32'h0000_0200 (claim/complete register address of target 0).
REQ-002 SHALL have parameter ID_W, default 7 (interrupt ID width, matches the PLIC irq_id width).
REQ-003 SHALL have port clk_i, input, 1: the single clock.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port irq_i, input, 1: PLIC target notification.
REQ-006 SHALL have port tl_o, output, tlul_pkg::tl_h2d_t: TL-UL host request toward the PLIC.
REQ-007 SHALL have port tl_i, input, tlul_pkg::tl_d2h_t: TL-UL device response.
REQ-008 SHALL have port vec_valid_o, output, 1: claimed interrupt ID offered to the core.
REQ-009 SHALL have port vec_id_o, output, ID_W: claimed ID.
REQ-010 SHALL have port vec_ready_i, input, 1: core accepts the vector.
REQ-011 SHALL have port done_i, input, 1: single-cycle pulse; core finished its handler.
REQ-012 SHALL have port busy_o, output, 1: FSM not in IDLE.
REQ-013 SHALL have port err_o, output, 1: single-cycle pulse on bus error or timeout.

Function
REQ-014 SHALL implement states IDLE, CLM_REQ, CLM_RSP, DISPATCH, SERVICE, CMP_REQ, CMP_RSP.
REQ-015 SHALL move IDLE->CLM_REQ on the cycle after irq_i is sampled high; irq_i is ignored in every other state.
REQ-016 In CLM_REQ SHALL drive a_valid=1, a_opcode=Get, a_address=CC_ADDR, a_size=2, a_mask=4'hF, a_source=0, holding all fields stable until a_valid&&a_ready, then go to CLM_RSP.
REQ-017 SHALL hold d_ready=1 in CLM_RSP and CMP_RSP, and 0 in all other states.
REQ-018 In CLM_RSP on d_valid SHALL capture d_data[ID_W-1:0] into vec_id_o.
REQ-019 On a CLM_RSP capture SHALL go to DISPATCH if the ID is nonzero and d_error=0.
REQ-020 Captured ID==0 (spurious) SHALL return to IDLE with no complete write and no err_o.
REQ-021 In DISPATCH SHALL assert vec_valid_o with vec_id_o stable; on vec_valid_o&&vec_ready_i go to SERVICE in the next cycle.
REQ-022 In SERVICE SHALL wait for done_i; done_i in any other state SHALL be ignored.
REQ-023 In CMP_REQ SHALL issue PutFullData to CC_ADDR with a_data={zero-pad, vec_id_o}, a_mask=4'hF, a_size=2, held stable until accepted, then go to CMP_RSP.
REQ-024 In CMP_RSP on d_valid SHALL return to IDLE.
REQ-025 On d_valid with d_error=1 in CLM_RSP or CMP_RSP SHALL pulse err_o for one cycle and return to IDLE; there is no retry.
REQ-026 SHALL have at most one outstanding TL transaction; a_valid SHALL never assert in a *_RSP state.
REQ-027 d_valid outside the *_RSP states SHALL be ignored.
REQ-028 Minimum latency: irq_i high at cycle 0 -> a_valid at cycle 1; with zero-wait bus, vec_valid_o no earlier than cycle 3.
REQ-029 busy_o SHALL equal (state!=IDLE), registered.

Reset
REQ-030 rst_i high SHALL, asynchronously, force state IDLE.
REQ-031 rst_i high SHALL, asynchronously, force a_valid=0, d_ready=0, vec_valid_o=0, vec_id_o=0, busy_o=0, err_o=0, and timeout counter=0.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no complete write; the PLIC-side re-sync is software's responsibility.

Configuration
REQ-033 Macro IRQ_CLAIM_TIMEOUT_EN defined: an 8-bit counter SHALL run in CLM_RSP and CMP_RSP and clear on state entry.
REQ-034 With IRQ_CLAIM_TIMEOUT_EN, reaching 255 without d_valid SHALL pulse err_o and return to IDLE.
REQ-035 Macro undefined: SHALL have no counter and wait indefinitely for d_valid.

Verification
REQ-036 Basic flow: irq_i=1, bus returns ID 5, vec_ready_i=1, done_i pulse -> vec_id_o=5; then a PutFullData with a_data=32'h5 to CC_ADDR; then IDLE with busy_o=0.
REQ-037 Spurious claim: bus returns ID 0 -> no vec_valid_o, no PutFullData, err_o=0, back in IDLE.
REQ-038 Bus stall: a_ready held low for 10 cycles in CLM_REQ and vec_ready_i held low 5 cycles -> a_* fields and vec_id_o stable throughout.
REQ-039 Bus error: d_error=1 on the claim response -> err_o high exactly 1 cycle, no dispatch.
REQ-040 Reset: rst_i pulsed during SERVICE with ID 9 -> all outputs 0 immediately, no complete write issued.
REQ-041 With IRQ_CLAIM_TIMEOUT_EN: no d_valid after the claim -> err_o pulses 255 cycles after CLM_RSP entry, then IDLE.

Source files
------------

// File: rtl/irq_claim_agent.sv
// PLIC claim/complete agent: claims an interrupt over TL-UL, hands the ID to the
// core, and writes it back as the completion. Optional: IRQ_CLAIM_TIMEOUT_EN.
package tlul_pkg;
  localparam logic [2:0] PutFullData   = 3'h0;
  localparam logic [2:0] Get           = 3'h4;
  localparam logic [2:0] AccessAck     = 3'h0;
  localparam logic [2:0] AccessAckData = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module irq_claim_agent
  import tlul_pkg::*;
#(
  parameter logic [31:0] CC_ADDR = 32'h0000_0200,
  parameter int          ID_W    = 7
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            irq_i,
  output tl_h2d_t         tl_o,
  input  tl_d2h_t         tl_i,
  output logic            vec_valid_o,
  output logic [ID_W-1:0] vec_id_o,
  input  logic            vec_ready_i,
  input  logic            done_i,
  output logic            busy_o,
  output logic            err_o
);
  typedef enum logic [2:0] {
    IDLE, CLM_REQ, CLM_RSP, DISPATCH, SERVICE, CMP_REQ, CMP_RSP
  } state_e;

  state_e          state, state_n;
  logic [ID_W-1:0] vec_id_q;
  logic            err_n, err_q, busy_q, tmo;
  logic            in_rsp;

  assign in_rsp = (state == CLM_RSP) || (state == CMP_RSP);

`ifdef IRQ_CLAIM_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Clears on every state change so each response phase gets a fresh window.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                        tmo_cnt <= '0;
    else if (!in_rsp || state_n != state) tmo_cnt <= '0;
    else                              tmo_cnt <= tmo_cnt + 8'd1;
  end

  assign tmo = in_rsp && (tmo_cnt == 8'd254);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      vec_id_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state  <= state_n;
      err_q  <= err_n;
      busy_q <= (state_n != IDLE);
      if (state == CLM_RSP && tl_i.d_valid) vec_id_q <= tl_i.d_data[ID_W-1:0];
    end
  end

  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    unique case (state)
      IDLE:     if (irq_i) state_n = CLM_REQ;
      CLM_REQ:  if (tl_i.a_ready) state_n = CLM_RSP;
      CLM_RSP: begin
        if (tl_i.d_valid) begin
          if (tl_i.d_error) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end else if (tl_i.d_data[ID_W-1:0] == '0) begin
            state_n = IDLE;  // spurious claim: nothing to complete
          end else begin
            state_n = DISPATCH;
          end
        end else if (tmo) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      DISPATCH: if (vec_ready_i) state_n = SERVICE;
      SERVICE:  if (done_i) state_n = CMP_REQ;
      CMP_REQ:  if (tl_i.a_ready) state_n = CMP_RSP;
      CMP_RSP: begin
        if (tl_i.d_valid) begin
          state_n = IDLE;
          err_n   = tl_i.d_error;
        end else if (tmo) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    tl_o         = '0;
    tl_o.d_ready = in_rsp;
    if (state == CLM_REQ || state == CMP_REQ) begin
      tl_o.a_valid   = 1'b1;
      tl_o.a_opcode  = (state == CLM_REQ) ? Get : PutFullData;
      tl_o.a_size    = 2'd2;
      tl_o.a_address = CC_ADDR;
      tl_o.a_mask    = 4'hF;
      tl_o.a_data    = (state == CMP_REQ) ? 32'(vec_id_q) : 32'h0;
    end
  end

  assign vec_valid_o = (state == DISPATCH);
  assign vec_id_o    = vec_id_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

  logic unused_tl;
  assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                       tl_i.d_sink, tl_i.d_data};
endmodule
